accel_core_weight_dispatch: RTL

- Upstream feeder of accel_core_mul_top.
- Holds one layer's per-neuron weight rows (weights plus bias as the last element) in an internal store, loaded by the core through a simple write port.
- On start, fills the three weight slots w1/w2/w3 one byte per cycle and raises meta_data.in_use on each filled slot.
- Refills a slot after its release_wN, until every neuron of the layer has been dispatched.

---
 rtl/accel_core_weight_dispatch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/accel_core_weight_dispatch.sv
// Weight dispatcher: holds one layer's neuron rows and streams them, one byte per
// cycle, into three weight slots consumed by the multiply stage.

typedef struct packed {
    logic       in_use;
    logic [7:0] neuron_idx;
    logic [7:0] data_len;
} t_weight_meta;

typedef struct packed {
    t_weight_meta    meta_data;
    logic [7:0][7:0] data;
} t_buffer_weights;

module accel_core_weight_dispatch #(
    parameter int unsigned MAX_NEURONS = 16,
    parameter int unsigned WEIGHT_LEN  = 8,
    localparam int unsigned NW = $clog2(MAX_NEURONS),
    localparam int unsigned LW = $clog2(WEIGHT_LEN + 1)
) (
    input  logic            Clock,
    input  logic            Rst,
    input  logic            wr_en,
    input  logic [NW-1:0]   wr_neuron,
    input  logic [LW-1:0]   wr_idx,
    input  logic [7:0]      wr_data,
    input  logic            start,
    input  logic [NW:0]     neuron_count,
    input  logic [LW-1:0]   data_len,
    input  logic            release_w1,
    input  logic            release_w2,
    input  logic            release_w3,
    output t_buffer_weights w1,
    output t_buffer_weights w2,
    output t_buffer_weights w3,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned CW = (WEIGHT_LEN > 1) ? $clog2(WEIGHT_LEN) : 1;

    typedef enum logic [0:0] {StIdle, StRun} top_st_e;
    typedef enum logic [1:0] {SlEmpty, SlLoading, SlReady} slot_st_e;

    top_st_e         st;
    slot_st_e        slot_st  [3];
    t_buffer_weights slot_buf [3];
    logic [7:0]      store    [MAX_NEURONS][WEIGHT_LEN];

    logic [NW:0]     n_total;
    logic [NW:0]     next_neuron;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   ld_cnt;
    logic [1:0]      ld_slot;
    logic [NW-1:0]   ld_row;

    logic [2:0]      rel;
    logic [2:0]      eff_empty;
    logic            any_loading;
    logic            ld_last;
    logic            ld_free;
    logic            alloc;
    logic            layer_done;
    logic            start_ok;
    logic [1:0]      alloc_slot;
    logic [7:0]      rd_byte;

    function automatic t_buffer_weights fresh_buf(input logic [NW-1:0] row,
                                                  input logic [LW-1:0] len);
        fresh_buf = '0;
        fresh_buf.meta_data.neuron_idx = 8'(row);
        fresh_buf.meta_data.data_len   = 8'(len);
    endfunction

    // A slot being released, and a loader on its last byte, already count as free so
    // back-to-back loads and refills lose no cycle.
    always_comb begin
        rel         = {release_w3, release_w2, release_w1};
        eff_empty   = '0;
        any_loading = 1'b0;
        for (int s = 0; s < 3; s++) begin
            eff_empty[s] = (slot_st[s] == SlEmpty) || (slot_st[s] == SlReady && rel[s]);
            any_loading  = any_loading || (slot_st[s] == SlLoading);
        end
        ld_last    = (ld_cnt == len_q - 1'b1);
        ld_free    = !any_loading || ld_last;
        alloc_slot = eff_empty[0] ? 2'd0 : (eff_empty[1] ? 2'd1 : 2'd2);
        alloc      = ld_free && (next_neuron < n_total) && (|eff_empty);
        layer_done = (next_neuron == n_total) && (&eff_empty);
        start_ok   = (data_len != '0) && (32'(data_len) <= WEIGHT_LEN)
                     && (32'(neuron_count) <= MAX_NEURONS);
        rd_byte    = store[ld_row][CW'(ld_cnt)];
    end

    always_ff @(posedge Clock) begin
        if (wr_en && !busy && 32'(wr_idx) < WEIGHT_LEN && 32'(wr_neuron) < MAX_NEURONS) begin
            store[wr_neuron][CW'(wr_idx)] <= wr_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            st          <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            n_total     <= '0;
            next_neuron <= '0;
            len_q       <= '0;
            ld_cnt      <= '0;
            ld_slot     <= '0;
            ld_row      <= '0;
            for (int s = 0; s < 3; s++) begin
                slot_st[s]  <= SlEmpty;
                slot_buf[s] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            for (int s = 0; s < 3; s++) begin
                if (slot_st[s] == SlReady && rel[s]) begin
                    slot_st[s]                   <= SlEmpty;
                    slot_buf[s].meta_data.in_use <= 1'b0;
                end
            end

            if (any_loading) begin
                slot_buf[ld_slot].data[3'(ld_cnt)] <= rd_byte;
                ld_cnt <= ld_cnt + 1'b1;
                if (ld_last) begin
                    slot_st[ld_slot]                   <= SlReady;
                    slot_buf[ld_slot].meta_data.in_use <= 1'b1;
                end
            end

            unique case (st)
                StIdle: begin
                    if (start) begin
                        if (start_ok) begin
                            st          <= StRun;
                            busy        <= 1'b1;
                            n_total     <= neuron_count;
                            len_q       <= data_len;
                            next_neuron <= '0;
                            if (neuron_count != '0) begin
                                slot_st[0]  <= SlLoading;
                                slot_buf[0] <= fresh_buf('0, data_len);
                                ld_slot     <= 2'd0;
                                ld_cnt      <= '0;
                                ld_row      <= '0;
                                next_neuron <= {{NW{1'b0}}, 1'b1};
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (alloc) begin
                        slot_st[alloc_slot]  <= SlLoading;
                        slot_buf[alloc_slot] <= fresh_buf(NW'(next_neuron), len_q);
                        ld_slot     <= alloc_slot;
                        ld_cnt      <= '0;
                        ld_row      <= NW'(next_neuron);
                        next_neuron <= next_neuron + 1'b1;
                    end else if (layer_done) begin
                        st   <= StIdle;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: st <= StIdle;
            endcase
        end
    end

    assign w1 = slot_buf[0];
    assign w2 = slot_buf[1];
    assign w3 = slot_buf[2];

endmodule
